// File: rtl/instr_mem_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_pkg
// Shared definitions for the instruction memory loader:
//   state_t        - loader/fetch FSM states
//   NOP_OPCODE     - byte presented to the CPU while no program is running
//   HALT_OPCODE    - halt opcode; also returned for addresses outside the program
//   DEFAULT_DEPTH  - default number of program bytes
//   fetch_hit()    - true when a PC falls inside the loaded program
// -----------------------------------------------------------------------------
package instr_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      RUN    = 2'd2,
      HALTED = 2'd3
   } state_t;

   localparam logic [7:0] NOP_OPCODE    = 8'h00;
   localparam logic [7:0] HALT_OPCODE   = 8'hF0;
   localparam int         DEFAULT_DEPTH = 32;

   // The full 8-bit PC is compared against the program length so that
   // addresses beyond the program (including pc >= DEPTH) never alias
   // into the RAM through the truncated read address.
   function automatic logic fetch_hit(input logic [7:0] pc,
                                      input logic [8:0] count);
      return ({1'b0, pc} < count);
   endfunction

endpackage

// File: rtl/instr_mem_ram.sv
// -----------------------------------------------------------------------------
// instr_mem_ram
// DEPTH x 8 program RAM: synchronous write port, asynchronous read port.
// Contents are not reset.
// Ports:
//   clk    in   write clock, rising edge
//   we     in   write enable
//   waddr  in   write address (AW bits)
//   wdata  in   write byte
//   raddr  in   read address (AW bits)
//   rdata  out  read byte (combinational)
// -----------------------------------------------------------------------------
module instr_mem_ram #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
// Program memory for Master_System. A host streams a program in over a
// byte-wide valid/ready port; the block then serves registered fetches
// addressed by the CPU PC and freezes the stream once HALT is fetched.
// Ports:
//   CLK         in   clock, rising edge
//   CLB         in   synchronous active-high reset
//   load_start  in   pulse: begin or restart a program load
//   load_valid  in   load beat valid
//   load_data   in   load beat byte
//   load_last   in   final beat of the program
//   load_ready  out  beat accepted this cycle (high throughout LOAD)
//   pc          in   fetch address from the CPU
//   instr       out  registered fetched instruction
//   run         out  program loaded and executing
//   halted      out  HALT fetched, stream frozen
//   load_count  out  beats stored in the current program (0..DEPTH)
//   overflow    out  sticky: beats were discarded past DEPTH
// -----------------------------------------------------------------------------
module instr_mem_loader
   import instr_mem_pkg::*;
#(
   parameter int         DEPTH   = DEFAULT_DEPTH,
   parameter int         AW      = 5,
   parameter logic [7:0] NOP_OP  = NOP_OPCODE,
   parameter logic [7:0] HALT_OP = HALT_OPCODE
) (
   input  logic          CLK,
   input  logic          CLB,
   input  logic          load_start,
   input  logic          load_valid,
   input  logic [7:0]    load_data,
   input  logic          load_last,
   output logic          load_ready,
   input  logic [7:0]    pc,
   output logic [7:0]    instr,
   output logic          run,
   output logic          halted,
   output logic [AW:0]   load_count,
   output logic          overflow
);

   localparam logic [AW:0] FULL = DEPTH[AW:0];

   state_t        state, state_nxt;
   logic [AW-1:0] wptr, wptr_nxt;
   logic [AW:0]   count_nxt;
   logic          overflow_nxt;
   logic [7:0]    instr_nxt;
   logic          we;
   logic [7:0]    rdata;
   logic [7:0]    fetch;

   instr_mem_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (CLK),
      .we    (we),
      .waddr (wptr),
      .wdata (load_data),
      .raddr (pc[AW-1:0]),
      .rdata (rdata)
   );

   always_ff @(posedge CLK) begin
      if (CLB) begin
         state      <= IDLE;
         wptr       <= '0;
         load_count <= '0;
         overflow   <= 1'b0;
         instr      <= NOP_OP;
      end else begin
         state      <= state_nxt;
         wptr       <= wptr_nxt;
         load_count <= count_nxt;
         overflow   <= overflow_nxt;
         instr      <= instr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wptr_nxt     = wptr;
      count_nxt    = load_count;
      overflow_nxt = overflow;
      instr_nxt    = instr;
      we           = 1'b0;
      load_ready   = (state == LOAD);
      run          = (state == RUN);
      halted       = (state == HALTED);
      fetch        = fetch_hit(pc, 9'(load_count)) ? rdata : HALT_OP;

      // load_start wins over everything, including a beat presented in the
      // same cycle: that beat is dropped and the new program starts empty.
      if (load_start) begin
         state_nxt    = LOAD;
         wptr_nxt     = '0;
         count_nxt    = '0;
         overflow_nxt = 1'b0;
         instr_nxt    = NOP_OP;
      end else begin
         case (state)
            IDLE: begin
               instr_nxt = NOP_OP;
            end
            LOAD: begin
               instr_nxt = NOP_OP;
               if (load_valid) begin
                  if (load_count < FULL) begin
                     we        = 1'b1;
                     wptr_nxt  = wptr + 1'b1;
                     count_nxt = load_count + 1'b1;
                  end else begin
                     overflow_nxt = 1'b1;
                  end
                  // A discarded final beat still ends the load.
                  if (load_last) begin
                     state_nxt = RUN;
                  end
               end
            end
            RUN: begin
               instr_nxt = fetch;
               if (fetch == HALT_OP) begin
                  state_nxt = HALTED;
               end
            end
            HALTED: begin
               instr_nxt = HALT_OP;
            end
            default: begin
               state_nxt = IDLE;
               instr_nxt = NOP_OP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

   localparam int AW = 5;

   logic          CLK = 1'b0;
   logic          CLB;
   logic          load_start;
   logic          load_valid;
   logic [7:0]    load_data;
   logic          load_last;
   logic          load_ready;
   logic [7:0]    pc;
   logic [7:0]    instr;
   logic          run;
   logic          halted;
   logic [AW:0]   load_count;
   logic          overflow;

   instr_mem_loader #(
      .DEPTH   (32),
      .AW      (AW),
      .NOP_OP  (8'h00),
      .HALT_OP (8'hF0)
   ) dut (
      .CLK        (CLK),
      .CLB        (CLB),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .pc         (pc),
      .instr      (instr),
      .run        (run),
      .halted     (halted),
      .load_count (load_count),
      .overflow   (overflow)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        rst;
      logic        ls;
      logic        lv;
      logic [7:0]  ld;
      logic        ll;
      logic [7:0]  pc;
      logic [7:0]  e_instr;
      logic        e_ready;
      logic        e_run;
      logic        e_halted;
      logic [AW:0] e_cnt;
      logic        e_ovf;
   } vec_t;

   vec_t sb[$];
   vec_t tbl[$];
   int   tests = 0;
   int   fails = 0;
   int   vidx  = 0;

   function automatic vec_t mk(input logic rst, input logic ls, input logic lv,
                               input logic [7:0] ld, input logic ll, input logic [7:0] p,
                               input logic [7:0] ei, input logic er, input logic eru,
                               input logic eh, input int ec, input logic eo);
      vec_t v;
      v.rst = rst; v.ls = ls; v.lv = lv; v.ld = ld; v.ll = ll; v.pc = p;
      v.e_instr = ei; v.e_ready = er; v.e_run = eru; v.e_halted = eh;
      v.e_cnt = ec[AW:0]; v.e_ovf = eo;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [7:0] got,
                      input logic [7:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL vec%0d %s: got %h, expected %h", idx, nm, got, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expected outputs, and compare
   // them just after the edge that should produce them.
   task automatic step(input vec_t v);
      vec_t e;
      CLB        = v.rst;
      load_start = v.ls;
      load_valid = v.lv;
      load_data  = v.ld;
      load_last  = v.ll;
      pc         = v.pc;
      sb.push_back(v);
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      chk("instr",      vidx, instr,              e.e_instr);
      chk("load_ready", vidx, {7'd0, load_ready}, {7'd0, e.e_ready});
      chk("run",        vidx, {7'd0, run},        {7'd0, e.e_run});
      chk("halted",     vidx, {7'd0, halted},     {7'd0, e.e_halted});
      chk("load_count", vidx, {2'd0, load_count}, {2'd0, e.e_cnt});
      chk("overflow",   vidx, {7'd0, overflow},   {7'd0, e.e_ovf});
      vidx++;
   endtask

   logic [7:0] prog [19] = '{8'hD5, 8'h50, 8'hD3, 8'h51, 8'hD0, 8'h10, 8'h21,
                             8'h52, 8'hB0, 8'h00, 8'h00, 8'h00, 8'hDD, 8'hAF,
                             8'hD0, 8'hD1, 8'h00, 8'h00, 8'hF0};

   initial begin
      CLB = 1'b1; load_start = 1'b0; load_valid = 1'b0;
      load_data = 8'h00; load_last = 1'b0; pc = 8'h00;

      // ---- table: reset, 19-byte program load, fetches, HALT ----
      //           rst ls lv ld     ll pc      instr  rdy run hlt cnt ovf
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'd0,  8'h00, 0, 0, 0, 0,  0));
      tbl.push_back(mk(0, 0, 1, 8'h55, 1, 8'd0,  8'h00, 0, 0, 0, 0,  0));
      tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'd0,  8'h00, 1, 0, 0, 0,  0));
      for (int i = 0; i < 19; i++) begin
         tbl.push_back(mk(0, 0, 1, prog[i], i == 18, 8'd0,
                          8'h00, i != 18, i == 18, 0, i + 1, 0));
      end
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'd0,  8'hD5, 0, 1, 0, 19, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'd7,  8'h52, 0, 1, 0, 19, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'd12, 8'hDD, 0, 1, 0, 19, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'd13, 8'hAF, 0, 1, 0, 19, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'd25, 8'hF0, 0, 0, 1, 19, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'd0,  8'hF0, 0, 0, 1, 19, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'd4,  8'hF0, 0, 0, 1, 19, 0));
      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // ---- restart from HALTED with a simultaneous beat (dropped) ----
      step(mk(0, 1, 1, 8'h77, 1, 8'd0, 8'h00, 1, 0, 0, 0, 0));
      step(mk(0, 0, 0, 8'h00, 0, 8'd0, 8'h00, 1, 0, 0, 0, 0));

      // ---- valid toggling 1,0,1,0: two writes only ----
      step(mk(0, 0, 1, 8'hA1, 0, 8'd0, 8'h00, 1, 0, 0, 1, 0));
      step(mk(0, 0, 0, 8'h99, 0, 8'd0, 8'h00, 1, 0, 0, 1, 0));
      step(mk(0, 0, 1, 8'hA2, 0, 8'd0, 8'h00, 1, 0, 0, 2, 0));
      step(mk(0, 0, 0, 8'h98, 1, 8'd0, 8'h00, 1, 0, 0, 2, 0));
      step(mk(0, 0, 1, 8'hA3, 1, 8'd0, 8'h00, 0, 1, 0, 3, 0));
      step(mk(0, 0, 0, 8'h00, 0, 8'd1, 8'hA2, 0, 1, 0, 3, 0));
      step(mk(0, 0, 0, 8'h00, 0, 8'd0, 8'hA1, 0, 1, 0, 3, 0));
      step(mk(0, 0, 0, 8'h00, 0, 8'd2, 8'hA3, 0, 1, 0, 3, 0));
      step(mk(0, 0, 0, 8'h00, 0, 8'd3, 8'hF0, 0, 0, 1, 3, 0));

      // ---- overflow: 34 beats into a 32-deep memory ----
      step(mk(0, 1, 0, 8'h00, 0, 8'd0, 8'h00, 1, 0, 0, 0, 0));
      for (int i = 1; i <= 34; i++) begin
         step(mk(0, 0, 1, 8'(8'h20 + i), i == 34, 8'd0,
                 8'h00, i != 34, i == 34, 0, (i > 32) ? 32 : i, i > 32));
      end
      step(mk(0, 0, 0, 8'h00, 0, 8'd31, 8'h40, 0, 1, 0, 32, 1));
      step(mk(0, 0, 0, 8'h00, 0, 8'd0,  8'h21, 0, 1, 0, 32, 1));
      step(mk(0, 0, 0, 8'h00, 0, 8'd32, 8'hF0, 0, 0, 1, 32, 1));

      // ---- reset in the middle of a load, then a 1-byte program ----
      step(mk(0, 1, 0, 8'h00, 0, 8'd0, 8'h00, 1, 0, 0, 0, 0));
      step(mk(0, 0, 1, 8'hD1, 0, 8'd0, 8'h00, 1, 0, 0, 1, 0));
      step(mk(0, 0, 1, 8'hD2, 0, 8'd0, 8'h00, 1, 0, 0, 2, 0));
      step(mk(0, 0, 1, 8'hD3, 0, 8'd0, 8'h00, 1, 0, 0, 3, 0));
      step(mk(1, 0, 1, 8'hD4, 0, 8'd0, 8'h00, 0, 0, 0, 0, 0));
      step(mk(0, 0, 1, 8'hD5, 1, 8'd0, 8'h00, 0, 0, 0, 0, 0));
      step(mk(0, 1, 0, 8'h00, 0, 8'd0, 8'h00, 1, 0, 0, 0, 0));
      step(mk(0, 0, 1, 8'hD7, 1, 8'd0, 8'h00, 0, 1, 0, 1, 0));
      step(mk(0, 0, 0, 8'h00, 0, 8'd0, 8'hD7, 0, 1, 0, 1, 0));
      step(mk(0, 0, 0, 8'h00, 0, 8'd1, 8'hF0, 0, 0, 1, 1, 0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
